// File: rtl/rv32i_reg_scoreboard.sv
// RV32I register hazard scoreboard: per-register outstanding-write counters with
// writeback bypass, RAW/saturation stalls and a flush -> drain -> clear sequence.
module rv32i_reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rden,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rd_decode,
    input  logic       issue,
    input  logic [4:0] wb_rd,
    input  logic       wb_wen,
    input  logic       flush,
    input  logic       pipe_empty,
    output logic       rs1_busy,
    output logic       rs2_busy,
    output logic       rd_busy,
    output logic       stall,
    output logic       clear_status,
    output logic [5:0] busy_count
);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    logic             clear_status_q;
    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic [CNT_W-1:0] eff   [NUM_REGS];
    logic [5:0]       busy_count_q;
    logic [5:0]       busy_count_d;
    logic             full;
    logic             issue_acc;

    // A write retiring this cycle is already visible through the RF write-through path.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            eff[r] = cnt_q[r];
            if (wb_wen && wb_rd == 5'(r) && cnt_q[r] != '0) begin
                eff[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    assign rs1_busy  = rden && rs1 != 5'd0 && eff[rs1] != '0;
    assign rs2_busy  = rden && rs2 != 5'd0 && eff[rs2] != '0;
    assign rd_busy   = rd_decode != 5'd0 && eff[rd_decode] != '0;
    assign full      = issue && rd_decode != 5'd0 && eff[rd_decode] == CNT_MAX;
    assign stall     = (state_q != IDLE) || (issue && (rs1_busy || rs2_busy)) || full;
    assign issue_acc = issue && !stall && !flush && rd_decode != 5'd0;

    always_comb begin
        logic inc;
        logic dec;
        // NOTE: every combinational output gets a default before any conditional
        // update, so no path leaves it unassigned and no latch is inferred.
        busy_count_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc      = issue_acc && rd_decode == 5'(r);
            dec      = wb_wen && wb_rd == 5'(r) && cnt_q[r] != '0;
            cnt_d[r] = cnt_q[r];
            if (r != 0) begin
                if (state_q == CLEAR) begin
                    cnt_d[r] = '0;
                end else if (inc && !dec) begin
                    cnt_d[r] = cnt_q[r] + CNT_W'(1);
                end else if (dec && !inc) begin
                    cnt_d[r] = cnt_q[r] - CNT_W'(1);
                end
            end
            if (cnt_d[r] != '0) begin
                busy_count_d = busy_count_d + 6'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: the counter array is reset explicitly; stale in-flight counts
            // after reset would stall decode forever, so it cannot be left to RAM init.
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            busy_count_q <= '0;
        end else begin
            if (wb_wen && wb_rd != 5'd0) begin
                assert (cnt_q[wb_rd] != '0)
                else $error("scoreboard underflow: writeback to x%0d with no outstanding write", wb_rd);
            end
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            cnt_q        <= cnt_d;
            busy_count_q <= busy_count_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= IDLE;
            clear_status_q <= 1'b0;
        end else begin
            clear_status_q <= 1'b0;
            case (state_q)
                IDLE:    if (flush) state_q <= DRAIN;
                DRAIN: begin
                    if (pipe_empty) begin
                        state_q        <= CLEAR;
                        clear_status_q <= 1'b1;
                    end
                end
                CLEAR:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clear_status = clear_status_q;
    assign busy_count   = busy_count_q;

endmodule

// File: tb/tb_rv32i_reg_scoreboard.sv
// Self-checking bench for rv32i_reg_scoreboard: directed scenarios followed by random
// traffic, all compared against an integer-array model of outstanding writes.
module tb_rv32i_reg_scoreboard;

    logic       CLK = 1'b0;
    logic       RST;
    logic       rden;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd_decode;
    logic       issue;
    logic [4:0] wb_rd;
    logic       wb_wen;
    logic       flush;
    logic       pipe_empty;
    logic       rs1_busy;
    logic       rs2_busy;
    logic       rd_busy;
    logic       stall;
    logic       clear_status;
    logic [5:0] busy_count;

    int checks   = 0;
    int failures = 0;

    // Model: outstanding writes per register and a phase (0 normal, 1 draining, 2 clearing).
    int m_cnt [32];
    int m_phase;

    rv32i_reg_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .rden         (rden),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd_decode    (rd_decode),
        .issue        (issue),
        .wb_rd        (wb_rd),
        .wb_wen       (wb_wen),
        .flush        (flush),
        .pipe_empty   (pipe_empty),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rd_busy      (rd_busy),
        .stall        (stall),
        .clear_status (clear_status),
        .busy_count   (busy_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_phase = 0;
    endfunction

    function automatic int m_eff(input int r);
        if (r == 0) return 0;
        if (wb_wen && int'(wb_rd) == r && m_cnt[r] > 0) return m_cnt[r] - 1;
        return m_cnt[r];
    endfunction

    function automatic bit m_src_busy(input int r);
        return rden && r != 0 && m_eff(r) > 0;
    endfunction

    function automatic bit m_stall();
        bit raw;
        bit sat;
        raw = issue && (m_src_busy(int'(rs1)) || m_src_busy(int'(rs2)));
        sat = issue && rd_decode != 0 && m_eff(int'(rd_decode)) == 3;
        return m_phase != 0 || raw || sat;
    endfunction

    function automatic int m_nonzero();
        int n = 0;
        for (int r = 0; r < 32; r++) if (m_cnt[r] != 0) n++;
        return n;
    endfunction

    // Apply one cycle of decode/writeback inputs and check the combinational outputs.
    task automatic drive(input bit d_rden, input int a, input int b, input int d, input bit d_issue,
                         input int w, input bit d_wen, input bit d_flush, input bit d_pe);
        rden       = d_rden;
        rs1        = a[4:0];
        rs2        = b[4:0];
        rd_decode  = d[4:0];
        issue      = d_issue;
        wb_rd      = w[4:0];
        wb_wen     = d_wen;
        flush      = d_flush;
        pipe_empty = d_pe;
        #2;
        check("rs1_busy", rs1_busy, m_src_busy(int'(rs1)));
        check("rs2_busy", rs2_busy, m_src_busy(int'(rs2)));
        check("rd_busy", rd_busy, rd_decode != 0 && m_eff(int'(rd_decode)) > 0);
        check("stall", stall, m_stall());
    endtask

    // Advance the model and the DUT by one edge, then check registered outputs.
    task automatic tick();
        bit acc;
        acc = m_phase == 0 && issue && !m_stall() && !flush && rd_decode != 0;
        if (m_phase == 2) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        end else begin
            if (wb_wen && wb_rd != 0 && m_cnt[wb_rd] > 0) m_cnt[wb_rd]--;
            if (acc) m_cnt[rd_decode]++;
        end
        case (m_phase)
            0:       if (flush) m_phase = 1;
            1:       if (pipe_empty) m_phase = 2;
            default: m_phase = 0;
        endcase
        @(posedge CLK);
        #1;
        check("busy_count", busy_count, m_nonzero());
        check("clear_status", clear_status, m_phase == 2);
    endtask

    task automatic idle_inputs();
        rden = 0; rs1 = 0; rs2 = 0; rd_decode = 0; issue = 0;
        wb_rd = 0; wb_wen = 0; flush = 0; pipe_empty = 0;
    endtask

    initial begin
        int a, b, d, w;
        bit en;

        RST = 1'b1;
        idle_inputs();
        model_reset();
        #12;
        check("reset_stall", stall, 0);
        check("reset_clear_status", clear_status, 0);
        check("reset_busy_count", busy_count, 0);
        check("reset_rs1_busy", rs1_busy, 0);
        #1 RST = 1'b0;
        @(posedge CLK);
        #1;

        // Basic issue, RAW stall on rs1, then same-cycle writeback bypass.
        drive(0, 0, 0, 5, 1, 0, 0, 0, 0);
        check("t1_issue_no_stall", stall, 0);
        tick();
        check("t1_busy_count", busy_count, 1);
        drive(1, 5, 0, 6, 1, 0, 0, 0, 0);
        check("t1_raw_rs1_busy", rs1_busy, 1);
        check("t1_raw_stall", stall, 1);
        tick();
        drive(1, 5, 0, 6, 1, 5, 1, 0, 0);
        check("t1_bypass_rs1", rs1_busy, 0);
        check("t1_bypass_stall", stall, 0);
        tick();
        drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
        check("t1_x5_retired", rs1_busy, 0);
        tick();
        drive(0, 0, 0, 0, 0, 6, 1, 0, 0);
        tick();
        check("t1_drained", busy_count, 0);

        // Counter saturation on x7 and same-cycle issue/writeback at the limit.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 7, 1, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 7, 1, 0, 0, 0, 0);
        check("t2_full_stall", stall, 1);
        check("t2_full_rd_busy", rd_busy, 1);
        tick();
        drive(0, 0, 0, 7, 1, 7, 1, 0, 0);
        check("t2_wb_unblocks", stall, 0);
        tick();
        drive(0, 0, 0, 7, 1, 0, 0, 0, 0);
        check("t2_still_full", stall, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 7, 1, 0, 0);
            tick();
        end
        check("t2_drained", busy_count, 0);

        // x0 is never tracked.
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 1, 0, 1, 0, 0);
            check("t3_x0_rs1", rs1_busy, 0);
            tick();
            check("t3_x0_count", busy_count, 0);
        end

        // Flush with a 4-cycle drain, then clear.
        drive(0, 0, 0, 3, 1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 4, 1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 9, 1, 0, 0, 0, 0); tick();
        check("t4_three_busy", busy_count, 3);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 10, 1, 0, 0, 0, 0);
            check("t4_drain_stall", stall, 1);
            tick();
        end
        drive(0, 0, 0, 10, 1, 0, 0, 0, 1);
        check("t4_drain_exit_stall", stall, 1);
        tick();
        check("t4_clear_pulse", clear_status, 1);
        check("t4_clear_count", busy_count, 3);
        drive(0, 0, 0, 10, 1, 0, 0, 1, 0);
        check("t4_clear_stall", stall, 1);
        tick();
        check("t4_pulse_done", clear_status, 0);
        check("t4_cleared", busy_count, 0);
        drive(0, 0, 0, 10, 1, 0, 0, 0, 0);
        check("t4_idle_again", stall, 0);
        tick();
        drive(0, 0, 0, 0, 0, 10, 1, 0, 0);
        tick();

        // Flush wins over a same-cycle issue; 1-cycle drain when the pipe is already empty.
        drive(0, 0, 0, 11, 1, 0, 0, 1, 1);
        tick();
        check("t4b_issue_dropped", busy_count, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        check("t4b_short_drain", clear_status, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Simultaneous issue and writeback on x12.
        drive(0, 0, 0, 12, 1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 12, 1, 12, 1, 0, 0);
        check("t5_rd_busy_bypass", rd_busy, 0);
        check("t5_no_stall", stall, 0);
        tick();
        check("t5_count", busy_count, 1);
        drive(0, 0, 0, 12, 0, 0, 0, 0, 0);
        check("t5_still_outstanding", rd_busy, 1);
        tick();
        drive(0, 0, 0, 0, 0, 12, 1, 0, 0);
        tick();

        // Asynchronous reset in the middle of a drain.
        drive(0, 0, 0, 3, 1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t6_draining", stall, 1);
        #2 RST = 1'b1;
        model_reset();
        #1;
        check("t6_async_stall", stall, 0);
        check("t6_async_clear", clear_status, 0);
        check("t6_async_count", busy_count, 0);
        #1 RST = 1'b0;
        @(posedge CLK);
        #1;
        drive(0, 0, 0, 5, 1, 0, 0, 0, 0);
        check("t6_first_issue", stall, 0);
        tick();
        check("t6_first_count", busy_count, 1);
        drive(0, 0, 0, 0, 0, 5, 1, 0, 0);
        tick();

        // Random traffic over x0..x7; writebacks only target registers with outstanding writes.
        for (int i = 0; i < 600; i++) begin
            a  = $urandom_range(0, 7);
            b  = $urandom_range(0, 7);
            d  = $urandom_range(0, 7);
            w  = $urandom_range(0, 7);
            en = (w == 0 || m_cnt[w] > 0) && ($urandom_range(0, 1) == 1);
            drive($urandom_range(0, 1) == 1, a, b, d, $urandom_range(0, 2) != 0, w, en,
                  m_phase == 0 && $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
